// File: rtl/cmac_mon_pkg.sv
// Shared definitions for the CMAC link monitor: state encoding, default
// parameters and the per-state control output decode.
package cmac_mon_pkg;

   localparam int DEF_ALIGN_DEBOUNCE   = 16;
   localparam int DEF_RESYNC_TIMEOUT   = 1024;
   localparam int DEF_FORCE_RESYNC_LEN = 4;
   localparam int DEF_CNT_W            = 16;

   typedef enum logic [2:0] {
      ST_DOWN         = 3'd0,
      ST_DEBOUNCE     = 3'd1,
      ST_UP           = 3'd2,
      ST_REMOTE_FAULT = 3'd3,
      ST_RESYNC       = 3'd4
   } mon_state_t;

   typedef struct packed {
      logic rx_en;
      logic tx_en;
      logic lfi;
      logic rfi;
      logic force_resync;
      logic link_up;
   } ctl_out_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Link-down states keep RX listening and advertise both faults to the peer.
   function automatic ctl_out_t decode_state(input mon_state_t s);
      ctl_out_t o;
      o.rx_en        = 1'b1;
      o.tx_en        = 1'b0;
      o.lfi          = 1'b1;
      o.rfi          = 1'b1;
      o.force_resync = 1'b0;
      o.link_up      = 1'b0;
      case (s)
         ST_UP, ST_REMOTE_FAULT: begin
            o.tx_en   = 1'b1;
            o.lfi     = 1'b0;
            o.rfi     = 1'b0;
            o.link_up = (s == ST_UP);
         end
         ST_RESYNC: o.force_resync = 1'b1;
         default: ;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on i_inc and sticks at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst)
         r_count <= '0;
      else if (i_inc && (r_count != {W{1'b1}}))
         r_count <= r_count + W'(1);
   end

   assign o_count = r_count;

endmodule

// File: rtl/cmac_link_monitor.sv
// CMAC link bring-up monitor: debounces alignment, tracks remote fault and
// forces an RX resync when alignment never appears.
module cmac_link_monitor
   import cmac_mon_pkg::*;
#(
   parameter int ALIGN_DEBOUNCE   = DEF_ALIGN_DEBOUNCE,
   parameter int RESYNC_TIMEOUT   = DEF_RESYNC_TIMEOUT,
   parameter int FORCE_RESYNC_LEN = DEF_FORCE_RESYNC_LEN,
   parameter int CNT_W            = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_aligned,
   input  logic             rx_remote_fault,
   output logic             ctl_rx_enable,
   output logic             ctl_tx_enable,
   output logic             ctl_tx_send_lfi,
   output logic             ctl_tx_send_rfi,
   output logic             ctl_rx_force_resync,
   output logic             link_up,
   output logic [CNT_W-1:0] link_drop_cnt,
   output logic [CNT_W-1:0] resync_cnt
);

   localparam int TMR_MAX = max3(RESYNC_TIMEOUT, ALIGN_DEBOUNCE, FORCE_RESYNC_LEN);
   localparam int TMR_W   = $clog2(TMR_MAX);

   // The DOWN->DEBOUNCE edge is the first aligned sample, so DEBOUNCE exits
   // once its timer has seen ALIGN_DEBOUNCE-2 further cycles.
   localparam logic [TMR_W-1:0] TO_LAST = TMR_W'(RESYNC_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] DB_LAST = TMR_W'((ALIGN_DEBOUNCE >= 2) ? ALIGN_DEBOUNCE - 2 : 0);
   localparam logic [TMR_W-1:0] FR_LAST = TMR_W'(FORCE_RESYNC_LEN - 1);

   mon_state_t       r_state;
   mon_state_t       w_state_next;
   logic [TMR_W-1:0] r_timer;
   logic [TMR_W-1:0] w_timer_next;
   ctl_out_t         r_out;
   logic             w_drop_inc;
   logic             w_resync_inc;

   always_comb begin
      w_state_next = r_state;
      w_timer_next = r_timer + TMR_W'(1);
      w_drop_inc   = 1'b0;
      w_resync_inc = 1'b0;
      case (r_state)
         ST_DOWN: begin
            if (rx_aligned) begin
               w_state_next = ST_DEBOUNCE;
               w_timer_next = '0;
            end else if (r_timer == TO_LAST) begin
               w_state_next = ST_RESYNC;
               w_timer_next = '0;
               w_resync_inc = 1'b1;
            end
         end
         ST_DEBOUNCE: begin
            if (!rx_aligned) begin
               w_state_next = ST_DOWN;
               w_timer_next = '0;
            end else if (r_timer == DB_LAST) begin
               w_state_next = ST_UP;
               w_timer_next = '0;
            end
         end
         ST_UP, ST_REMOTE_FAULT: begin
            w_timer_next = '0;
            if (!rx_aligned) begin
               w_state_next = ST_DOWN;
               w_drop_inc   = 1'b1;
            end else begin
               w_state_next = rx_remote_fault ? ST_REMOTE_FAULT : ST_UP;
            end
         end
         ST_RESYNC: begin
            // Alignment is ignored here so the resync pulse always runs full length.
            if (r_timer == FR_LAST) begin
               w_state_next = ST_DOWN;
               w_timer_next = '0;
            end
         end
         default: begin
            w_state_next = ST_DOWN;
            w_timer_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_DOWN;
         r_timer <= '0;
         r_out   <= '0;
      end else begin
         r_state <= w_state_next;
         r_timer <= w_timer_next;
         r_out   <= decode_state(w_state_next);
      end
   end

   sat_counter #(.W(CNT_W)) u_drop_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_drop_inc),
      .o_count (link_drop_cnt)
   );

   sat_counter #(.W(CNT_W)) u_resync_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_inc   (w_resync_inc),
      .o_count (resync_cnt)
   );

   assign ctl_rx_enable       = r_out.rx_en;
   assign ctl_tx_enable       = r_out.tx_en;
   assign ctl_tx_send_lfi     = r_out.lfi;
   assign ctl_tx_send_rfi     = r_out.rfi;
   assign ctl_rx_force_resync = r_out.force_resync;
   assign link_up             = r_out.link_up;

endmodule

// File: tb/tb_cmac_link_monitor.sv
// Self-checking bench for cmac_link_monitor: vector table, directed corner
// sequences and randomized traffic against a behavioural reference model.
module tb_cmac_link_monitor;

   localparam int AD  = 4;
   localparam int TO  = 32;
   localparam int FRL = 3;
   localparam int CW  = 4;
   localparam int CMAX = (1 << CW) - 1;

   // Output vector order: {rx_en, tx_en, lfi, rfi, force_resync, link_up}
   localparam logic [5:0] O_ZERO = 6'b000000;
   localparam logic [5:0] O_DOWN = 6'b101100;
   localparam logic [5:0] O_UP   = 6'b110001;
   localparam logic [5:0] O_RF   = 6'b110000;
   localparam logic [5:0] O_RS   = 6'b101110;

   logic          clk = 1'b0;
   logic          rst;
   logic          rx_aligned;
   logic          rx_remote_fault;
   logic          ctl_rx_enable;
   logic          ctl_tx_enable;
   logic          ctl_tx_send_lfi;
   logic          ctl_tx_send_rfi;
   logic          ctl_rx_force_resync;
   logic          link_up;
   logic [CW-1:0] link_drop_cnt;
   logic [CW-1:0] resync_cnt;
   logic [5:0]    outs;

   int checks = 0;
   int errors = 0;

   // Reference model: history counters rather than a state encoding.
   bit m_in_rst;
   bit m_linked;
   bit m_rf;
   int m_resync_left;
   int m_run;
   int m_idle;
   int m_drops;
   int m_resyncs;

   cmac_link_monitor #(
      .ALIGN_DEBOUNCE   (AD),
      .RESYNC_TIMEOUT   (TO),
      .FORCE_RESYNC_LEN (FRL),
      .CNT_W            (CW)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .rx_aligned          (rx_aligned),
      .rx_remote_fault     (rx_remote_fault),
      .ctl_rx_enable       (ctl_rx_enable),
      .ctl_tx_enable       (ctl_tx_enable),
      .ctl_tx_send_lfi     (ctl_tx_send_lfi),
      .ctl_tx_send_rfi     (ctl_tx_send_rfi),
      .ctl_rx_force_resync (ctl_rx_force_resync),
      .link_up             (link_up),
      .link_drop_cnt       (link_drop_cnt),
      .resync_cnt          (resync_cnt)
   );

   always #5 clk = ~clk;

   assign outs = {ctl_rx_enable, ctl_tx_enable, ctl_tx_send_lfi, ctl_tx_send_rfi,
                  ctl_rx_force_resync, link_up};

   function automatic int sat_inc(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic model_step(input bit r, input bit a, input bit f);
      if (r) begin
         m_in_rst = 1'b1; m_linked = 1'b0; m_rf = 1'b0;
         m_resync_left = 0; m_run = 0; m_idle = 0; m_drops = 0; m_resyncs = 0;
      end else begin
         m_in_rst = 1'b0;
         if (m_resync_left > 0) begin
            m_resync_left--;
         end else if (m_linked) begin
            if (!a) begin
               m_linked = 1'b0; m_rf = 1'b0; m_run = 0; m_idle = 0;
               m_drops = sat_inc(m_drops);
            end else begin
               m_rf = f;
            end
         end else if (a) begin
            m_idle = 0;
            m_run++;
            if (m_run == AD) begin
               m_linked = 1'b1; m_rf = 1'b0; m_run = 0;
            end
         end else if (m_run > 0) begin
            m_run = 0; m_idle = 0;
         end else begin
            m_idle++;
            if (m_idle == TO) begin
               m_idle = 0;
               m_resync_left = FRL;
               m_resyncs = sat_inc(m_resyncs);
            end
         end
      end
   endtask

   function automatic logic [5:0] model_outs();
      if (m_in_rst)          return O_ZERO;
      if (m_resync_left > 0) return O_RS;
      if (m_linked)          return m_rf ? O_RF : O_UP;
      return O_DOWN;
   endfunction

   task automatic cycle(input bit r, input bit a, input bit f);
      rst = r; rx_aligned = a; rx_remote_fault = f;
      @(posedge clk);
      #1;
      model_step(r, a, f);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      bit         r;
      bit         a;
      bit         f;
      logic [5:0] exp_outs;
      int         exp_drop;
   } vec_t;

   vec_t tbl[13];

   initial begin
      int exp_d;
      int div;
      bit al;
      bit rf;
      bit rr;

      rst = 1'b1; rx_aligned = 1'b0; rx_remote_fault = 1'b0;

      // Vector table: glitch during debounce, then UP, REMOTE_FAULT, simultaneous drop.
      tbl[0]  = '{1'b1, 1'b0, 1'b0, O_ZERO, 0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, O_DOWN, 0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, O_DOWN, 0};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, O_DOWN, 0};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, O_DOWN, 0};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, O_DOWN, 0};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, O_DOWN, 0};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, O_DOWN, 0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, O_DOWN, 0};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, O_UP,   0};
      tbl[10] = '{1'b0, 1'b1, 1'b1, O_RF,   0};
      tbl[11] = '{1'b0, 1'b0, 1'b1, O_DOWN, 1};
      tbl[12] = '{1'b1, 1'b0, 1'b0, O_ZERO, 0};

      for (int i = 0; i < 13; i++) begin
         cycle(tbl[i].r, tbl[i].a, tbl[i].f);
         $display("vec %0d rst=%0b al=%0b rf=%0b outs=%b drop=%0d resync=%0d",
                  i, tbl[i].r, tbl[i].a, tbl[i].f, outs, link_drop_cnt, resync_cnt);
         chk($sformatf("vec%0d_outs", i), int'(outs), int'(tbl[i].exp_outs));
         chk($sformatf("vec%0d_drop", i), int'(link_drop_cnt), tbl[i].exp_drop);
         chk($sformatf("vec%0d_resync", i), int'(resync_cnt), 0);
      end

      // Resync timeout: pulse at cycles 32..34, repeating every 35 cycles.
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      for (int n = 1; n <= 75; n++) begin
         cycle(0, 0, 0);
         if (n == 1) chk("release_decode", int'(outs), int'(O_DOWN));
         chk($sformatf("resync_pulse_c%0d", n), int'(ctl_rx_force_resync),
             int'(((n >= 32) && (n <= 34)) || ((n >= 67) && (n <= 69))));
         if (n == 31) chk("resync_cnt_c31", int'(resync_cnt), 0);
         if (n == 32) chk("resync_cnt_c32", int'(resync_cnt), 1);
         if (n == 67) chk("resync_cnt_c67", int'(resync_cnt), 2);
      end
      $display("seq timeout resync_cnt=%0d", resync_cnt);

      // Alignment 10 cycles after reset: UP exactly 4 cycles later.
      cycle(1, 0, 0);
      for (int n = 1; n <= 10; n++) cycle(0, 0, 0);
      for (int n = 11; n <= 14; n++) begin
         cycle(0, 1, 0);
         chk($sformatf("bringup_link_up_c%0d", n), int'(link_up), int'(n == 14));
         chk($sformatf("bringup_tx_en_c%0d", n), int'(ctl_tx_enable), int'(n == 14));
         chk($sformatf("bringup_lfi_c%0d", n), int'(ctl_tx_send_lfi), int'(n != 14));
         chk($sformatf("bringup_rfi_c%0d", n), int'(ctl_tx_send_rfi), int'(n != 14));
      end
      chk("bringup_drop_cnt", int'(link_drop_cnt), 0);
      $display("seq bringup link_up=%0b", link_up);

      // Remote fault for 5 cycles, then combined fault and alignment loss.
      for (int k = 0; k < 5; k++) begin
         cycle(0, 1, 1);
         chk($sformatf("rf_link_up_%0d", k), int'(link_up), 0);
         chk($sformatf("rf_tx_en_%0d", k), int'(ctl_tx_enable), 1);
      end
      cycle(0, 1, 0);
      chk("rf_recover_link_up", int'(link_up), 1);
      cycle(0, 0, 1);
      chk("rf_drop_outs", int'(outs), int'(O_DOWN));
      chk("rf_drop_cnt", int'(link_drop_cnt), 1);
      $display("seq remote_fault drop=%0d", link_drop_cnt);

      // Drive the drop counter to all-ones minus 1, then 3 more drops.
      exp_d = 1;
      for (int d = 0; d < CMAX - 2 + 3; d++) begin
         for (int k = 0; k < AD; k++) cycle(0, 1, 0);
         chk("sat_reach_up", int'(link_up), 1);
         cycle(0, 0, 0);
         exp_d = sat_inc(exp_d);
         chk($sformatf("sat_drop_%0d", d), int'(link_drop_cnt), exp_d);
         $display("seq sat drop %0d cnt=%0d", d, link_drop_cnt);
      end
      chk("sat_final", int'(link_drop_cnt), CMAX);

      // Reset in the middle of a resync pulse.
      cycle(1, 0, 0);
      for (int n = 1; n <= 33; n++) cycle(0, 0, 0);
      chk("midpulse_active", int'(ctl_rx_force_resync), 1);
      cycle(1, 1, 0);
      chk("midpulse_rst_outs", int'(outs), int'(O_ZERO));
      chk("midpulse_rst_drop", int'(link_drop_cnt), 0);
      chk("midpulse_rst_resync", int'(resync_cnt), 0);
      cycle(0, 0, 0);
      chk("midpulse_release", int'(outs), int'(O_DOWN));
      $display("seq reset_midpulse outs=%b", outs);

      // Randomized traffic against the reference model.
      cycle(1, 0, 0);
      al = 1'b0; rf = 1'b0;
      for (int s = 0; s < 20; s++) begin
         case ($urandom_range(0, 2))
            0:       div = 3;
            1:       div = 12;
            default: div = 80;
         endcase
         for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, div - 1) == 0) al = ~al;
            if ($urandom_range(0, 5) == 0) rf = ~rf;
            rr = ($urandom_range(0, 999) == 0);
            cycle(rr, al, rf);
            chk("rand_outs", int'(outs), int'(model_outs()));
            chk("rand_drop", int'(link_drop_cnt), m_drops);
            chk("rand_resync", int'(resync_cnt), m_resyncs);
         end
         $display("rand seg %0d div=%0d drops=%0d resyncs=%0d", s, div, m_drops, m_resyncs);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmac_link_monitor.md
CMAC_LINK_MONITOR -- requirements
Module: cmac_link_monitor

Interface
REQ-001 Parameter ALIGN_DEBOUNCE, default 16: consecutive aligned cycles required before the link is declared up; legal range 1 or more.
REQ-002 Parameter RESYNC_TIMEOUT, default 1024: cycles in DOWN without alignment before a resync is forced; legal range 2 or more.
REQ-003 Parameter FORCE_RESYNC_LEN, default 4: width in cycles of the ctl_rx_force_resync pulse; legal range 1 or more.
REQ-004 Parameter CNT_W, default 16: width of the statistics counters.
REQ-005 Reset is rst, synchronous, active-high; clock is clk.
REQ-006 clk  in  1  CMAC core clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 rx_aligned  in  1  CMAC stat_rx_aligned.
REQ-009 rx_remote_fault  in  1  CMAC stat_rx_remote_fault.
REQ-010 ctl_rx_enable  out  1  CMAC RX enable.
REQ-011 ctl_tx_enable  out  1  CMAC TX enable.
REQ-012 ctl_tx_send_lfi  out  1  request to send local fault indication.
REQ-013 ctl_tx_send_rfi  out  1  request to send remote fault indication.
REQ-014 ctl_rx_force_resync  out  1  RX resync pulse.
REQ-015 link_up  out  1  link usable for traffic.
REQ-016 link_drop_cnt  out  CNT_W  count of transitions out of UP or REMOTE_FAULT caused by loss of alignment.
REQ-017 resync_cnt  out  CNT_W  count of forced resyncs.

Function
REQ-018 The FSM SHALL have exactly five states: DOWN, DEBOUNCE, UP, REMOTE_FAULT and RESYNC.
REQ-019 All outputs SHALL be registered and SHALL update on the same edge as the state register, taking the decode of the newly entered state (zero extra latency).
REQ-020 Output decode:
- DOWN: rx_en=1, tx_en=0, lfi=1, rfi=1, link_up=0.
- DEBOUNCE: same as DOWN.
- UP: rx_en=1, tx_en=1, lfi=0, rfi=0, link_up=1.
- REMOTE_FAULT: same as UP except link_up=0.
- RESYNC: same as DOWN, plus force_resync=1.
REQ-021 DOWN transitions:
- rx_aligned=1 -> DEBOUNCE, timer cleared.
- Otherwise the timer increments; on reaching RESYNC_TIMEOUT-1 -> RESYNC.
REQ-022 DEBOUNCE transitions:
- rx_aligned=0 -> DOWN, timer cleared.
- After ALIGN_DEBOUNCE consecutive aligned cycles, counting the DOWN->DEBOUNCE entry cycle -> UP.
REQ-023 UP transitions:
- rx_aligned=0 -> DOWN, link_drop_cnt increments.
- Else rx_remote_fault=1 -> REMOTE_FAULT.
REQ-024 REMOTE_FAULT transitions:
- rx_aligned=0 -> DOWN, link_drop_cnt increments.
- Else rx_remote_fault=0 -> UP.
REQ-025 RESYNC SHALL hold ctl_rx_force_resync high for exactly FORCE_RESYNC_LEN cycles, then go to DOWN with the timer cleared.
REQ-026 resync_cnt SHALL increment once, on RESYNC entry.
REQ-027 rx_aligned asserting during RESYNC SHALL NOT shorten the pulse.
REQ-028 Simultaneous loss of alignment and remote fault in UP SHALL go to DOWN; loss of alignment has priority.
REQ-029 Both counters SHALL saturate at all-ones and never wrap.
REQ-030 A single timer of width clog2(max(RESYNC_TIMEOUT, ALIGN_DEBOUNCE, FORCE_RESYNC_LEN)) SHALL be shared across states and cleared on every state change.

Reset
REQ-031 While rst=1: state=DOWN, timer=0, counters=0, and all 1-bit outputs=0.
REQ-032 On the first edge with rst=0, outputs SHALL take the decode of the state entered on that edge.
REQ-033 rst asserted in any state, including mid-resync-pulse, SHALL take effect on the next edge with no residual pulse.

Structure
REQ-034 State encodings and default parameter constants SHALL reside in shared package cmac_mon_pkg.
REQ-035 One sub-module, sat_counter (CNT_W-bit saturating incrementer with enable), SHALL be instantiated twice, once for each statistic.

Verification
REQ-036 Bench parameters: ALIGN_DEBOUNCE=4, RESYNC_TIMEOUT=32, FORCE_RESYNC_LEN=3.
REQ-037 Release rst with rx_aligned=0 -> rx_en, lfi and rfi are 1 on the first edge; at cycle 32 force_resync is high for exactly 3 cycles and resync_cnt=1; the cycle repeats every 35 cycles.
REQ-038 Raise rx_aligned 10 cycles after reset and hold it -> link_up and tx_en rise exactly 4 cycles later while lfi and rfi fall; link_drop_cnt stays 0.
REQ-039 Aligned for 3 cycles, low for 1, then aligned -> no UP after the first glitch; UP 4 cycles after the re-rise; no resync counted.
REQ-040 In UP, assert rx_remote_fault for 5 cycles -> link_up=0 for 5 cycles while tx_en stays 1, then link_up returns to 1; then drop rx_aligned together with the fault -> DOWN and link_drop_cnt=1.
REQ-041 Force link_drop_cnt to all-ones minus 1 and apply 3 link drops -> counter holds at all-ones; assert rst during a force_resync pulse -> the pulse ends on the next edge and counters read 0.
